sha256_padder: RTL and testbench

//  Upstream stage of core: accepts a message as a stream of 32-bit big-endian words,

---
 rtl/sha256_pkg.sv | 42 ++++
 rtl/sha256_padder.sv | 182 ++++++++++++++++++
 tb/tb_sha256_padder.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message padder: state encoding,
// padding constants and byte-lane helpers for partial 32-bit beats.
package sha256_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_PAD   = 2'd1,
    ST_ISSUE = 2'd2,
    ST_BUSY  = 2'd3
  } padder_state_t;

  localparam logic [31:0] MARKER_WORD = 32'h8000_0000;
  localparam logic [3:0]  LEN_HI_IDX  = 4'd14;
  localparam logic [3:0]  LEN_LO_IDX  = 4'd15;

  // Keep the first nbytes bytes of a big-endian word (byte 0 is [31:24]).
  function automatic logic [31:0] byte_mask(input logic [2:0] nbytes);
    logic [31:0] m;
    case (nbytes)
      3'd0:    m = 32'h0000_0000;
      3'd1:    m = 32'hFF00_0000;
      3'd2:    m = 32'hFFFF_0000;
      3'd3:    m = 32'hFFFF_FF00;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

  // 0x80 marker placed in the first byte lane after nbytes data bytes.
  function automatic logic [31:0] marker_at(input logic [2:0] nbytes);
    logic [31:0] m;
    case (nbytes)
      3'd0:    m = 32'h8000_0000;
      3'd1:    m = 32'h0080_0000;
      3'd2:    m = 32'h0000_8000;
      3'd3:    m = 32'h0000_0080;
      default: m = 32'h0000_0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sha256_padder.sv
// SHA-256 front end: packs a stream of big-endian 32-bit beats into 512-bit
// blocks, appends the 0x80 marker, zero fill and 64-bit bit length, hands
// each block to the hash core with init/next, and captures the final digest.
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int BYTE_CNT_W = 61
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic [2:0]   in_nbytes,
  input  logic         in_last,
  input  logic         core_ready,
  input  logic         core_digest_valid,
  input  logic [255:0] core_digest,
  output logic         core_init,
  output logic         core_next,
  output logic [511:0] core_block,
  output logic [255:0] digest,
  output logic         digest_valid
);

  padder_state_t         state_reg;
  logic [3:0]            idx_reg;
  logic [BYTE_CNT_W-1:0] cnt_reg;
  logic                  first_reg;
  logic                  marker_done_reg;
  logic                  final_reg;
  logic                  last_seen_reg;
  logic                  init_reg;
  logic                  next_reg;
  logic [255:0]          digest_reg;
  logic                  digest_valid_reg;

  logic [2:0]            eff_nbytes;
  logic [31:0]           load_word;
  logic [31:0]           pad_word;
  logic [31:0]           word_wdata;
  logic [63:0]           len_bits;
  logic                  load_fire;
  logic                  pad_fire;
  logic                  word_we;
  logic                  blk_done;

  assign in_ready     = (state_reg == ST_LOAD) && !reset;
  assign core_init    = init_reg;
  assign core_next    = next_reg;
  assign digest       = digest_reg;
  assign digest_valid = digest_valid_reg;

  assign load_fire = (state_reg == ST_LOAD) && in_valid;
  assign pad_fire  = (state_reg == ST_PAD);
  assign word_we   = load_fire || pad_fire;
  assign len_bits  = 64'({cnt_reg, 3'b000});

  // The core still shows the previous result during the pulse cycle, so
  // completion is only accepted once the pulse has dropped.
  assign blk_done = (state_reg == ST_BUSY) && core_ready && core_digest_valid
                    && !init_reg && !next_reg;

  // Decode the incoming beat and the padding word for the current index
  always_comb begin
    eff_nbytes = in_nbytes;
    if (in_nbytes > 3'd4 || (in_nbytes == 3'd0 && !in_last)) begin
      eff_nbytes = 3'd4;
    end

    load_word = in_data & byte_mask(eff_nbytes);
    if (in_last) begin
      load_word = load_word | marker_at(eff_nbytes);
    end

    pad_word = 32'h0;
    if (!marker_done_reg) begin
      pad_word = MARKER_WORD;
    end else if (idx_reg == LEN_HI_IDX) begin
      pad_word = len_bits[63:32];
    end else if (idx_reg == LEN_LO_IDX && final_reg) begin
      pad_word = len_bits[31:0];
    end

    word_wdata = pad_fire ? pad_word : load_word;
  end

  // Block buffer: sixteen word registers, one written per cycle at idx
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_word
      logic [31:0] word_reg;

      // Capture the addressed word; wipe the block once the core is done
      always_ff @(posedge clk) begin
        if (reset || blk_done) begin
          word_reg <= '0;
        end else if (word_we && idx_reg == 4'(gi)) begin
          word_reg <= word_wdata;
        end
      end

      assign core_block[511-32*gi -: 32] = word_reg;
    end
  endgenerate

  // Control FSM: load, pad, hand block to core, wait for result
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_LOAD;
      idx_reg          <= '0;
      cnt_reg          <= '0;
      first_reg        <= 1'b1;
      marker_done_reg  <= 1'b0;
      final_reg        <= 1'b0;
      last_seen_reg    <= 1'b0;
      init_reg         <= 1'b0;
      next_reg         <= 1'b0;
      digest_reg       <= '0;
      digest_valid_reg <= 1'b0;
    end else begin
      init_reg <= 1'b0;
      next_reg <= 1'b0;
      case (state_reg)
        ST_LOAD: begin
          if (in_valid) begin
            idx_reg          <= idx_reg + 4'd1;
            cnt_reg          <= cnt_reg + BYTE_CNT_W'(eff_nbytes);
            digest_valid_reg <= 1'b0;
            if (in_last) begin
              last_seen_reg   <= 1'b1;
              marker_done_reg <= (eff_nbytes < 3'd4);
              state_reg       <= (idx_reg == LEN_LO_IDX) ? ST_ISSUE : ST_PAD;
            end else if (idx_reg == LEN_LO_IDX) begin
              state_reg <= ST_ISSUE;
            end
          end
        end
        ST_PAD: begin
          idx_reg <= idx_reg + 4'd1;
          if (!marker_done_reg) begin
            marker_done_reg <= 1'b1;
          end else if (idx_reg == LEN_HI_IDX) begin
            final_reg <= 1'b1;
          end
          if (idx_reg == LEN_LO_IDX) begin
            state_reg <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (core_ready) begin
            init_reg  <= first_reg;
            next_reg  <= !first_reg;
            first_reg <= 1'b0;
            state_reg <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (blk_done) begin
            idx_reg <= '0;
            if (final_reg) begin
              digest_reg       <= core_digest;
              digest_valid_reg <= 1'b1;
              cnt_reg          <= '0;
              first_reg        <= 1'b1;
              marker_done_reg  <= 1'b0;
              final_reg        <= 1'b0;
              last_seen_reg    <= 1'b0;
              state_reg        <= ST_LOAD;
            end else if (last_seen_reg) begin
              state_reg <= ST_PAD;
            end else begin
              state_reg <= ST_LOAD;
            end
          end
        end
        default: state_reg <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
// Bench for sha256_padder: a behavioural SHA-256 core model, directed
// messages with hand-built expected blocks, and a scoreboard monitor that
// checks every init/next block and every captured digest.
module tb_sha256_padder;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic [2:0]   in_nbytes;
  logic         in_last;
  logic         core_ready;
  logic         core_digest_valid;
  logic [255:0] core_digest;
  logic         core_init;
  logic         core_next;
  logic [511:0] core_block;
  logic [255:0] digest;
  logic         digest_valid;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sha256_padder #(.BYTE_CNT_W(61)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .in_nbytes         (in_nbytes),
    .in_last           (in_last),
    .core_ready        (core_ready),
    .core_digest_valid (core_digest_valid),
    .core_digest       (core_digest),
    .core_init         (core_init),
    .core_next         (core_next),
    .core_block        (core_block),
    .digest            (digest),
    .digest_valid      (digest_valid)
  );

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [2047:0] K_FLAT = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [255:0] ABC_DIG =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DIG =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    a = h[255:224]; b = h[223:192]; c = h[191:160]; d = h[159:128];
    e = h[127:96];  f = h[95:64];   g = h[63:32];   hh = h[31:0];
    for (int t = 0; t < 64; t++) begin
      s1 = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
      t1 = hh + s1 + ((e & f) ^ (~e & g)) + K_FLAT[2047-32*t -: 32] + w[t];
      s0 = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
      t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
            h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
  endfunction

  function automatic logic [31:0] pat(input int j);
    return {8'(4*j), 8'(4*j+1), 8'(4*j+2), 8'(4*j+3)};
  endfunction

  // ---------------- core model ----------------
  logic         stall_en;
  logic [255:0] core_pend;
  int           busy_cnt;

  always @(posedge clk) begin
    if (reset) begin
      core_ready        <= 1'b1;
      core_digest_valid <= 1'b0;
      core_digest       <= '0;
      core_pend         <= '0;
      busy_cnt          <= 0;
    end else if (busy_cnt == 0 && (core_init || core_next)) begin
      core_pend         <= sha_compress(core_init ? IV : core_digest, core_block);
      core_ready        <= 1'b0;
      core_digest_valid <= 1'b0;
      busy_cnt          <= int'($urandom_range(3, 8));
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else if (busy_cnt == 1) begin
      busy_cnt          <= 0;
      core_ready        <= 1'b1;
      core_digest_valid <= 1'b1;
      core_digest       <= core_pend;
    end else if (stall_en) begin
      core_ready <= ($urandom_range(0, 3) != 0);
    end else begin
      core_ready <= 1'b1;
    end
  end

  // ---------------- input legality ----------------
  always @(posedge clk) begin
    if (!reset && in_valid) begin
      assert (in_nbytes <= 3'd4 && (in_nbytes != 3'd0 || in_last))
        else $error("illegal beat: nbytes=%0d last=%0b", in_nbytes, in_last);
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic         is_init;
    logic [511:0] blk;
  } exp_blk_t;

  exp_blk_t     blk_q [$];
  logic [255:0] dig_q [$];
  logic         dv_prev = 1'b0;

  always @(negedge clk) begin
    exp_blk_t     e;
    logic [255:0] d;
    if (!reset) begin
      if (core_init || core_next) begin
        checks++;
        if (core_init && core_next) begin
          failures++;
          $display("FAIL pulse_excl: got init=1 next=1 required at most one");
        end
        checks++;
        if (blk_q.size() == 0) begin
          failures++;
          $display("FAIL block_unexpected: got init=%0b blk=%h required no block", core_init, core_block);
        end else begin
          e = blk_q.pop_front();
          if (e.is_init != core_init || e.blk != core_block) begin
            failures++;
            $display("FAIL block: got init=%0b blk=%h required init=%0b blk=%h",
                     core_init, core_block, e.is_init, e.blk);
          end else begin
            $display("block ok: init=%0b w0=%h w14=%h w15=%h", core_init,
                     core_block[511:480], core_block[63:32], core_block[31:0]);
          end
        end
        checks++;
        if (in_ready) begin
          failures++;
          $display("FAIL ready_busy: got in_ready=1 required 0 while block issued");
        end
      end
      if (digest_valid && !dv_prev) begin
        checks++;
        if (dig_q.size() == 0) begin
          failures++;
          $display("FAIL digest_unexpected: got %h required none", digest);
        end else begin
          d = dig_q.pop_front();
          if (digest != d) begin
            failures++;
            $display("FAIL digest: got %h required %h", digest, d);
          end else begin
            $display("digest ok: %h", digest);
          end
        end
      end
    end
    dv_prev = digest_valid;
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 512'(in_ready), 512'(0));
    chk({tag, "_core_init"}, 512'(core_init), 512'(0));
    chk({tag, "_core_next"}, 512'(core_next), 512'(0));
    chk({tag, "_core_block"}, core_block, 512'(0));
    chk({tag, "_digest"}, 512'(digest), 512'(0));
    chk({tag, "_digest_valid"}, 512'(digest_valid), 512'(0));
    $display("reset check %s done", tag);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [2:0] nb, input logic last, input int max_gap);
    int t;
    repeat ($urandom_range(0, max_gap)) @(negedge clk);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = d;
    in_nbytes = nb;
    in_last   = last;
    t = 0;
    while (!in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL beat_timeout: got in_ready=0 for 500 cycles required 1");
      in_valid = 1'b0;
      in_last  = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      $display("beat sent: data=%h nbytes=%0d last=%0b", d, nb, last);
    end
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((blk_q.size() != 0 || dig_q.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (blk_q.size() != 0 || dig_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: got %0d blocks %0d digests pending required 0",
               name, blk_q.size(), dig_q.size());
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic [511:0] b1, b2;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_nbytes = '0;
    in_last   = 1'b0;
    stall_en  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_init");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // "abc" in one beat
    b1 = '0;
    b1[511:480] = 32'h6162_6380;
    b1[31:0]    = 32'h0000_0018;
    blk_q.push_back('{1'b1, b1});
    dig_q.push_back(ABC_DIG);
    send_beat(32'h6162_6300, 3'd3, 1'b1, 0);
    wait_drain("abc");

    // empty message; data bits must be masked away
    b1 = '0;
    b1[511:480] = 32'h8000_0000;
    blk_q.push_back('{1'b1, b1});
    dig_q.push_back(EMPTY_DIG);
    send_beat(32'hDEAD_BEEF, 3'd0, 1'b1, 0);
    wait_drain("empty");

    // 56 bytes: marker fills word 14, length spills into a second block
    b1 = '0;
    b2 = '0;
    for (int j = 0; j < 14; j++) b1[511-32*j -: 32] = pat(j);
    b1[63:32] = 32'h8000_0000;
    b2[31:0]  = 32'h0000_01C0;
    blk_q.push_back('{1'b1, b1});
    blk_q.push_back('{1'b0, b2});
    dig_q.push_back(sha_compress(sha_compress(IV, b1), b2));
    for (int j = 0; j < 14; j++) send_beat(pat(j), 3'd4, (j == 13), 0);
    wait_drain("msg56");

    // 64 bytes: full data block, then marker-only padding block
    b1 = '0;
    b2 = '0;
    for (int j = 0; j < 16; j++) b1[511-32*j -: 32] = pat(j + 20);
    b2[511:480] = 32'h8000_0000;
    b2[31:0]    = 32'h0000_0200;
    blk_q.push_back('{1'b1, b1});
    blk_q.push_back('{1'b0, b2});
    dig_q.push_back(sha_compress(sha_compress(IV, b1), b2));
    for (int j = 0; j < 16; j++) send_beat(pat(j + 20), 3'd4, (j == 15), 0);
    wait_drain("msg64");

    // two "abc" messages back to back with input gaps and core stalls
    stall_en = 1'b1;
    b1 = '0;
    b1[511:480] = 32'h6162_6380;
    b1[31:0]    = 32'h0000_0018;
    blk_q.push_back('{1'b1, b1});
    dig_q.push_back(ABC_DIG);
    blk_q.push_back('{1'b1, b1});
    dig_q.push_back(ABC_DIG);
    send_beat(32'h6162_6300, 3'd3, 1'b1, 3);
    send_beat(32'h6162_63AA, 3'd3, 1'b1, 3);
    wait_drain("abc_x2");
    stall_en = 1'b0;

    // reset while padding; the abandoned message must produce nothing
    send_beat(32'h6162_6300, 3'd3, 1'b1, 0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_pad");
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("rst_no_block", 512'(blk_q.size()), 512'(0));
    b1 = '0;
    b1[511:480] = 32'h6162_6380;
    b1[31:0]    = 32'h0000_0018;
    blk_q.push_back('{1'b1, b1});
    dig_q.push_back(ABC_DIG);
    send_beat(32'h6162_6300, 3'd3, 1'b1, 0);
    wait_drain("abc_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
